regex_stream_ctx: RTL and testbench

- Parametrised successor of the per-category regex stream wrapper used in the packet-inspection DPI core.
- Saves and restores an external DFA matcher's state per stream ID across packets.
- Keeps a saturating per-stream match count plus a global count, readable through a side port.
- Adds abort handling, same-stream forwarding and valid-tracked context memory. The matcher is reached through ports, so one wrapper serves every category engine.

---
 rtl/regex_stream_pkg.sv | 16 +
 rtl/regex_ctx_mem.sv | 77 +++++++
 rtl/regex_stream_ctx.sv | 177 +++++++++++++++++
 tb/tb_regex_stream_ctx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regex_stream_pkg.sv
// Shared types and helpers for the per-stream regex context wrapper.
//   state_e  : wrapper FSM state (IDLE between packets, RUN inside a packet)
//   sat_inc  : saturating increment for counters up to 32 bits wide
package regex_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Callers zero-extend their counter and pass the all-ones value of their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        sat_inc = (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/regex_ctx_mem.sv
// Per-stream DFA context store: a non-reset state array plus a reset valid bit
// per stream. One write port and one registered read port. The read result is
// already masked, so its output can drive the matcher load bus directly.
//   clk, rst       : clock, synchronous active-high reset (clears valid bits and read reg)
//   wr_en/addr/data: context write; also marks the entry valid
//   rd_en/addr     : read request, result appears after the next edge
//   rd_force_zero  : return 0 regardless of stored context (fresh stream)
//   rd_data        : registered read result
module regex_ctx_mem
    import regex_stream_pkg::*;
#(
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_addr,
    input  logic [STATE_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_addr,
    input  logic               rd_force_zero,
    output logic [STATE_W-1:0] rd_data
);

    logic [STATE_W-1:0]     mem_q [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q;
    logic [NUM_STREAMS-1:0] valid_d;
    logic [STATE_W-1:0]     rd_data_q;
    logic [STATE_W-1:0]     rd_data_d;
    logic                   wr_ok_c;

    // A write landing in the reset cycle is dropped.
    assign wr_ok_c = wr_en && !rst;

    // Read path: a same-edge write to the same entry is forwarded so the
    // caller sees the context it is committing right now.
    always_comb begin
        valid_d   = valid_q;
        rd_data_d = rd_data_q;
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
        end
        if (rd_en) begin
            if (rd_force_zero) begin
                rd_data_d = '0;
            end else if (wr_en && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else if (valid_q[rd_addr]) begin
                rd_data_d = mem_q[rd_addr];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Context array carries no reset; valid_q guards every read.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/regex_stream_ctx.sv
// Stream context wrapper around an external DFA matcher: restores matcher
// state per stream at packet start, saves it back at end of packet, and keeps
// saturating per-stream and total counts of matched packets.
//   clk, rst                 : clock, synchronous active-high reset
//   pkt_start, stream_id,
//   new_stream, enable       : packet start and its attributes
//   eop                      : end of packet (commit)
//   dfa_state_in(_vld)       : context load toward the matcher
//   dfa_accept, dfa_state_out: matcher feedback
//   fired                    : accept seen in current packet
//   pkt_done, abort          : commit / drop pulses
//   clr_counts               : clear all counters
//   cnt_rd_id, cnt_rd_data   : per-stream count read (1-cycle latency)
//   total_count              : saturating total of matched committed packets
module regex_stream_ctx
    import regex_stream_pkg::*;
#(
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = 6,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream,
    input  logic               enable,
    input  logic               eop,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic               dfa_accept,
    input  logic [STATE_W-1:0] dfa_state_out,
    output logic               fired,
    output logic               pkt_done,
    output logic               abort,
    input  logic               clr_counts,
    input  logic [SID_W-1:0]   cnt_rd_id,
    output logic [CNT_W-1:0]   cnt_rd_data,
    output logic [CNT_W-1:0]   total_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [SID_W-1:0]   sid_q, sid_d;
    logic               en_q, en_d;
    logic               fired_q, fired_d;
    logic               pkt_done_q, pkt_done_d;
    logic               abort_q, abort_d;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   count_q [NUM_STREAMS];
    logic [CNT_W-1:0]   count_d [NUM_STREAMS];
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   cnt_rd_q, cnt_rd_d;

    logic               load_c;
    logic               ctx_we_c;
    logic               inc_c;

    // Packet FSM: commit on eop happens before any same-cycle load.
    always_comb begin
        state_d    = state_q;
        sid_d      = sid_q;
        en_d       = en_q;
        fired_d    = fired_q;
        pkt_done_d = 1'b0;
        abort_d    = 1'b0;
        vld_d      = 1'b0;
        load_c     = 1'b0;
        ctx_we_c   = 1'b0;
        inc_c      = 1'b0;

        case (state_q)
            IDLE: begin
                load_c = pkt_start;
            end
            RUN: begin
                fired_d = fired_q | dfa_accept;
                if (eop) begin
                    pkt_done_d = 1'b1;
                    state_d    = IDLE;
                    if (en_q) begin
                        ctx_we_c = 1'b1;
                        inc_c    = fired_q | dfa_accept;
                    end else begin
                        fired_d = 1'b0;
                    end
                end else if (pkt_start) begin
                    abort_d = 1'b1;
                end
                load_c = pkt_start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_c) begin
            state_d = RUN;
            sid_d   = stream_id;
            en_d    = enable;
            fired_d = 1'b0;
            vld_d   = 1'b1;
        end
    end

    // Counters: clear beats a same-edge increment; read returns pre-edge value.
    always_comb begin
        count_d  = count_q;
        total_d  = total_q;
        cnt_rd_d = count_q[cnt_rd_id];
        if (clr_counts) begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                count_d[i] = '0;
            end
            total_d = '0;
        end else if (inc_c) begin
            count_d[sid_q] = CNT_W'(sat_inc(32'(count_q[sid_q]), 32'(CNT_MAX)));
            total_d        = CNT_W'(sat_inc(32'(total_q), 32'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sid_q      <= '0;
            en_q       <= 1'b0;
            fired_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            abort_q    <= 1'b0;
            vld_q      <= 1'b0;
            total_q    <= '0;
            cnt_rd_q   <= '0;
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sid_q      <= sid_d;
            en_q       <= en_d;
            fired_q    <= fired_d;
            pkt_done_q <= pkt_done_d;
            abort_q    <= abort_d;
            vld_q      <= vld_d;
            total_q    <= total_d;
            cnt_rd_q   <= cnt_rd_d;
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    regex_ctx_mem #(
        .STATE_W     (STATE_W),
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W)
    ) u_ctx_mem (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (ctx_we_c),
        .wr_addr       (sid_q),
        .wr_data       (dfa_state_out),
        .rd_en         (load_c),
        .rd_addr       (stream_id),
        .rd_force_zero (new_stream),
        .rd_data       (dfa_state_in)
    );

    assign dfa_state_in_vld = vld_q;
    assign fired            = fired_q;
    assign pkt_done         = pkt_done_q;
    assign abort            = abort_q;
    assign cnt_rd_data      = cnt_rd_q;
    assign total_count      = total_q;

endmodule

// File: tb/tb_regex_stream_ctx.sv
// Bench for regex_stream_ctx: directed packet scenarios followed by random
// traffic, every cycle compared against a packet-level reference model.
// Counters are built 8 bits wide so saturation is reachable quickly.
module tb_regex_stream_ctx;

    localparam int unsigned STATE_W     = 11;
    localparam int unsigned NUM_STREAMS = 64;
    localparam int unsigned SID_W       = 6;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned CMAX        = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               pkt_start;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream;
    logic               enable;
    logic               eop;
    logic [STATE_W-1:0] dfa_state_in;
    logic               dfa_state_in_vld;
    logic               dfa_accept;
    logic [STATE_W-1:0] dfa_state_out;
    logic               fired;
    logic               pkt_done;
    logic               abort;
    logic               clr_counts;
    logic [SID_W-1:0]   cnt_rd_id;
    logic [CNT_W-1:0]   cnt_rd_data;
    logic [CNT_W-1:0]   total_count;

    always #5 clk = ~clk;

    regex_stream_ctx #(
        .STATE_W     (STATE_W),
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_start        (pkt_start),
        .stream_id        (stream_id),
        .new_stream       (new_stream),
        .enable           (enable),
        .eop              (eop),
        .dfa_state_in     (dfa_state_in),
        .dfa_state_in_vld (dfa_state_in_vld),
        .dfa_accept       (dfa_accept),
        .dfa_state_out    (dfa_state_out),
        .fired            (fired),
        .pkt_done         (pkt_done),
        .abort            (abort),
        .clr_counts       (clr_counts),
        .cnt_rd_id        (cnt_rd_id),
        .cnt_rd_data      (cnt_rd_data),
        .total_count      (total_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: stream contexts, counts and the open packet.
    int unsigned m_mem   [NUM_STREAMS];
    bit          m_valid [NUM_STREAMS];
    int unsigned m_count [NUM_STREAMS];
    int unsigned m_total;
    bit          m_in_pkt;
    bit          m_en;
    bit          m_fired;
    int unsigned m_sid;

    bit          e_vld, e_done, e_abort;
    int unsigned e_state_in, e_rd;

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        bit matched;
        matched = 1'b0;
        if (rst) begin
            m_in_pkt   = 1'b0;
            m_fired    = 1'b0;
            e_vld      = 1'b0;
            e_done     = 1'b0;
            e_abort    = 1'b0;
            e_state_in = 0;
            e_rd       = 0;
            m_total    = 0;
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                m_count[i] = 0;
                m_valid[i] = 1'b0;
            end
            return;
        end
        e_rd    = m_count[cnt_rd_id];
        e_vld   = 1'b0;
        e_done  = 1'b0;
        e_abort = 1'b0;
        if (m_in_pkt) begin
            if (dfa_accept) m_fired = 1'b1;
            if (eop) begin
                e_done   = 1'b1;
                m_in_pkt = 1'b0;
                if (m_en) begin
                    m_mem[m_sid]   = int'(dfa_state_out);
                    m_valid[m_sid] = 1'b1;
                    matched        = m_fired;
                end else begin
                    m_fired = 1'b0;
                end
            end else if (pkt_start) begin
                e_abort = 1'b1;
            end
        end
        if (matched) begin
            m_count[m_sid] = sat(m_count[m_sid]);
            m_total        = sat(m_total);
        end
        if (clr_counts) begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) m_count[i] = 0;
            m_total = 0;
        end
        if (pkt_start) begin
            m_sid      = int'(stream_id);
            m_en       = enable;
            m_fired    = 1'b0;
            m_in_pkt   = 1'b1;
            e_vld      = 1'b1;
            e_state_in = (new_stream || !m_valid[m_sid]) ? 0 : m_mem[m_sid];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("state_in_vld", 32'(dfa_state_in_vld), 32'(e_vld));
        check_eq("state_in",     32'(dfa_state_in),     e_state_in);
        check_eq("fired",        32'(fired),            32'(m_fired));
        check_eq("pkt_done",     32'(pkt_done),         32'(e_done));
        check_eq("abort",        32'(abort),            32'(e_abort));
        check_eq("cnt_rd_data",  32'(cnt_rd_data),      e_rd);
        check_eq("total_count",  32'(total_count),      m_total);
    endtask

    task automatic drive(input bit ps, input int unsigned sid, input bit nw, input bit en,
                         input bit e, input bit acc, input int unsigned so);
        rst           = 1'b0;
        clr_counts    = 1'b0;
        pkt_start     = ps;
        stream_id     = SID_W'(sid);
        new_stream    = nw;
        enable        = en;
        eop           = e;
        dfa_accept    = acc;
        dfa_state_out = STATE_W'(so);
    endtask

    initial begin
        for (int i = 0; i < int'(NUM_STREAMS); i++) begin
            m_mem[i] = 0; m_valid[i] = 1'b0; m_count[i] = 0;
        end
        m_total = 0; m_in_pkt = 0; m_en = 0; m_fired = 0; m_sid = 0;
        e_vld = 0; e_done = 0; e_abort = 0; e_state_in = 0; e_rd = 0;

        drive(0, 0, 0, 0, 0, 0, 0);
        cnt_rd_id = '0;
        rst = 1'b1;
        step(); step();
        check_eq("reset_total", 32'(total_count), 32'd0);

        // Fresh context on an invalid stream loads 0.
        drive(1, 5, 0, 1, 0, 0, 0); step();
        check_eq("load_invalid_vld", 32'(dfa_state_in_vld), 32'd1);
        check_eq("load_invalid_val", 32'(dfa_state_in), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 12'h011); step();

        // Matched packet on stream 3, then restore and new_stream override.
        cnt_rd_id = SID_W'(3);
        drive(1, 3, 0, 1, 0, 0, 0);      step();
        drive(0, 0, 0, 0, 0, 1, 0);      step();
        drive(0, 0, 0, 0, 0, 0, 0);      step();
        drive(0, 0, 0, 0, 1, 0, 'h2A);   step();
        check_eq("done_after_eop", 32'(pkt_done), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);      step();
        check_eq("count3_one", 32'(cnt_rd_data), 32'd1);
        check_eq("total_one",  32'(total_count), 32'd1);
        drive(1, 3, 0, 1, 0, 0, 0);      step();
        check_eq("restore_2a", 32'(dfa_state_in), 32'h2A);
        drive(0, 0, 0, 0, 1, 0, 'h2A);   step();
        drive(1, 3, 1, 1, 0, 0, 0);      step();
        check_eq("new_stream_zero", 32'(dfa_state_in), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 'h2A);   step();

        // Disabled category: fired visible, no commit.
        drive(1, 3, 0, 0, 0, 0, 0);      step();
        drive(0, 0, 0, 0, 0, 1, 0);      step();
        check_eq("disabled_fired", 32'(fired), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 'h3FF);  step();
        check_eq("disabled_done", 32'(pkt_done), 32'd1);
        drive(1, 3, 0, 1, 0, 0, 0);      step();
        check_eq("disabled_ctx_kept", 32'(dfa_state_in), 32'h2A);
        drive(0, 0, 0, 0, 1, 0, 'h2A);   step();

        // Back-to-back same stream forwards the committing state.
        drive(1, 7, 0, 1, 0, 0, 0);      step();
        drive(0, 0, 0, 0, 0, 1, 0);      step();
        drive(1, 7, 0, 1, 1, 0, 'h155);  step();
        check_eq("forward_155", 32'(dfa_state_in), 32'h155);

        // Start without eop aborts, then reset mid-packet.
        drive(1, 9, 0, 1, 0, 1, 0);      step();
        check_eq("abort_pulse", 32'(abort), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 0);      step();
        drive(0, 0, 0, 0, 1, 0, 0); rst = 1'b1; step();
        check_eq("reset_mid_fired", 32'(fired), 32'd0);
        check_eq("reset_mid_done",  32'(pkt_done), 32'd0);
        drive(1, 7, 0, 1, 0, 0, 0);      step();
        check_eq("reset_ctx_invalid", 32'(dfa_state_in), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 0);      step();

        // Saturation on stream 1.
        cnt_rd_id = SID_W'(1);
        for (int p = 0; p < int'(CMAX) + 4; p++) begin
            drive(1, 1, 0, 1, 0, 0, 0);  step();
            drive(0, 0, 0, 0, 1, 1, $urandom_range(0, 2047)); step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);      step();
        check_eq("count1_sat", 32'(cnt_rd_data), CMAX);
        check_eq("total_sat",  32'(total_count), CMAX);

        // Clear wins over a same-edge commit.
        drive(1, 1, 0, 1, 0, 1, 0);      step();
        drive(0, 0, 0, 0, 1, 1, 0); clr_counts = 1'b1; step();
        drive(0, 0, 0, 0, 0, 0, 0);      step();
        check_eq("clr_count1", 32'(cnt_rd_data), 32'd0);
        check_eq("clr_total",  32'(total_count), 32'd0);

        // Random traffic over a few streams to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2047));
            clr_counts = ($urandom_range(0, 99) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            cnt_rd_id  = SID_W'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
